// File: rtl/am_mod_pkg.sv
// am_mod_pkg: shared constants and helpers for the amplitude modulator.
// Holds the mode encodings, the drain FSM state encoding, the DAC midscale
// helper and a width-generic saturating clip used by the output stage.
package am_mod_pkg;

    localparam logic MODE_AM  = 1'b0;
    localparam logic MODE_ASK = 1'b1;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } am_state_e;

    // Plain bit constants so the state register can stay an ordinary logic vector.
    localparam logic [0:0] ST_RUN   = S_RUN;
    localparam logic [0:0] ST_DRAIN = S_DRAIN;

    // Offset-binary code for zero output: 2^(w-1). Callers size-cast the result.
    function automatic logic [63:0] midscale_code(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

    // Clip a signed value into the two's complement range of a w-bit word.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x,
                                                    input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // True when sat_clip would have changed the value.
    function automatic logic sat_hit(input logic signed [63:0] x,
                                     input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/am_mod_sat_round.sv
// am_mod_sat_round: final pipeline stage of a DAC path.
// Rounds a full-precision signed product half-up by SCALE_SH bits, clips it to
// OUT_W bits, flags clipping and emits an offset-binary DAC code. Data and flag
// hold their last value while no valid sample arrives.
module am_mod_sat_round
    import am_mod_pkg::*;
#(
    parameter int P_W      = 25,
    parameter int SCALE_SH = 11,
    parameter int OUT_W    = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic signed [P_W-1:0] i_prod,
    output logic                 o_valid,
    output logic [OUT_W-1:0]     o_data,
    output logic                 o_sat
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int SUM_W = P_W + 1;
    localparam logic signed [SUM_W-1:0] RND = SUM_W'(64'd1 << (SCALE_SH - 1));

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_shift;
    logic signed [OUT_W-1:0] w_y;
    logic                    w_sat;

    // Round half up, scale down, then clip into the DAC word.
    always_comb begin
        w_sum   = {i_prod[P_W-1], i_prod} + RND;
        w_shift = w_sum >>> SCALE_SH;
        w_y     = OUT_W'(sat_clip(64'(w_shift), OUT_W));
        w_sat   = sat_hit(64'(w_shift), OUT_W);
    end

    // Register the output; inverting the sign bit gives offset binary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= OUT_W'(midscale_code(OUT_W));
            o_sat   <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_data <= {~w_y[OUT_W-1], w_y[OUT_W-2:0]};
                o_sat  <= w_sat;
            end
        end
    end

endmodule

// File: rtl/am_mod_core.sv
// am_mod_core: pipelined AM / ASK modulator between ADC capture and the DAC.
// Four register stages: centred sample, envelope, product, round/saturate.
// A RUN/DRAIN FSM makes reconfiguration glitch-free: new settings wait in
// shadow registers until every sample of the old setting has left the pipe.
// Optional build macro AM_MOD_CLIP_CNT_EN adds the clip_cnt port and counter.
module am_mod_core
    import am_mod_pkg::*;
#(
    parameter int ADC_W    = 10,
    parameter int CAR_W    = 14,
    parameter int DEPTH_W  = 9,
    parameter int OUT_W    = 14,
    parameter int SIG_SH   = 1,
    parameter int SCALE_SH = ADC_W + 1 + CAR_W - OUT_W,
    parameter int LAT      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [ADC_W-1:0]    adc_data,
    input  logic [CAR_W-1:0]    carrier,
    input  logic                ask_bit,
    input  logic                cfg_mode,
    input  logic [DEPTH_W-1:0]  cfg_depth,
    input  logic [DEPTH_W-1:0]  cfg_space,
    input  logic                cfg_load,
    output logic                cfg_busy,
    output logic                out_valid,
    output logic [OUT_W-1:0]    out_data,
    output logic                sat_flag
`ifdef AM_MOD_CLIP_CNT_EN
    ,
    output logic [15:0]         clip_cnt
`endif
);

    localparam int E_W   = ADC_W + 1;
    localparam int P_W   = ADC_W + 1 + CAR_W;
    localparam int CNT_W = $clog2(LAT + 1);

    logic [0:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_act_mode;
    logic [DEPTH_W-1:0]   r_act_depth;
    logic [DEPTH_W-1:0]   r_act_space;
    logic                 r_sh_mode;
    logic [DEPTH_W-1:0]   r_sh_depth;
    logic [DEPTH_W-1:0]   r_sh_space;

    logic                 w_accept;
    logic                 w_load;

    logic                 r_s1_valid;
    logic signed [ADC_W-1:0] r_s1_sig;
    logic signed [CAR_W-1:0] r_s1_car;
    logic                 r_s1_ask;

    logic                 r_s2_valid;
    logic signed [E_W-1:0]   r_s2_env;
    logic signed [CAR_W-1:0] r_s2_car;

    logic                 r_s3_valid;
    logic signed [P_W-1:0]   r_s3_prod;

    logic signed [ADC_W-1:0] w_sig_raw;
    logic signed [ADC_W-1:0] w_sig;
    logic signed [E_W-1:0]   w_sig_ext;
    logic signed [E_W-1:0]   w_depth_ext;
    logic signed [E_W-1:0]   w_space_ext;
    logic signed [E_W-1:0]   w_env;
    logic signed [P_W-1:0]   w_prod;

    // Samples are only taken in RUN; a load is only honoured in RUN.
    assign w_accept = in_valid && (r_state == ST_RUN);
    assign w_load   = cfg_load && (r_state == ST_RUN);
    assign cfg_busy = (r_state == ST_DRAIN);

    // Flipping the MSB removes the offset-binary bias before the shift.
    assign w_sig_raw = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};
    assign w_sig     = w_sig_raw >>> SIG_SH;

    // Drain FSM: park the new config, wait LAT cycles, then make it active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_act_mode  <= MODE_AM;
            r_act_depth <= '0;
            r_act_space <= '0;
            r_sh_mode   <= MODE_AM;
            r_sh_depth  <= '0;
            r_sh_space  <= '0;
        end else if (r_state == ST_RUN) begin
            if (cfg_load) begin
                r_sh_mode  <= cfg_mode;
                r_sh_depth <= cfg_depth;
                r_sh_space <= cfg_space;
                r_cnt      <= CNT_W'(LAT - 1);
                r_state    <= ST_DRAIN;
            end
        end else begin
            if (r_cnt == '0) begin
                r_act_mode  <= r_sh_mode;
                r_act_depth <= r_sh_depth;
                r_act_space <= r_sh_space;
                r_state     <= ST_RUN;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Stage 1: centre and pre-scale the ADC sample, carry carrier and key along.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sig   <= '0;
            r_s1_car   <= '0;
            r_s1_ask   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sig <= w_sig;
                r_s1_car <= carrier;
                r_s1_ask <= ask_bit;
            end
        end
    end

    // Envelope: signal plus carrier offset in AM, mark/space level in ASK.
    always_comb begin
        w_sig_ext   = {r_s1_sig[ADC_W-1], r_s1_sig};
        w_depth_ext = {{(E_W - DEPTH_W){1'b0}}, r_act_depth};
        w_space_ext = {{(E_W - DEPTH_W){1'b0}}, r_act_space};
        w_env       = w_sig_ext + w_depth_ext;
        if (r_act_mode == MODE_ASK) begin
            w_env = r_s1_ask ? w_depth_ext : w_space_ext;
        end
    end

    // Stage 2: register the envelope next to its carrier sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_env   <= '0;
            r_s2_car   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_env <= w_env;
                r_s2_car <= r_s1_car;
            end
        end
    end

    // Full-precision signed product, no truncation before rounding.
    assign w_prod = P_W'(r_s2_env) * P_W'(r_s2_car);

    // Stage 3: register the product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_prod  <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_prod <= w_prod;
            end
        end
    end

    am_mod_sat_round #(
        .P_W      (P_W),
        .SCALE_SH (SCALE_SH),
        .OUT_W    (OUT_W)
    ) u_sat_round (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_s3_valid),
        .i_prod  (r_s3_prod),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_sat   (sat_flag)
    );

`ifdef AM_MOD_CLIP_CNT_EN
    logic [15:0] r_clip_cnt;

    // Count clipped outputs, sticking at full scale; restarts with each new config.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clip_cnt <= '0;
        end else if (w_load) begin
            r_clip_cnt <= '0;
        end else if (out_valid && sat_flag && (r_clip_cnt != 16'hFFFF)) begin
            r_clip_cnt <= r_clip_cnt + 16'd1;
        end
    end

    assign clip_cnt = r_clip_cnt;
`endif

endmodule

// File: tb/tb_am_mod_core.sv
// tb_am_mod_core: scoreboard bench for am_mod_core.
// dutA uses the default scaling; dutB uses SCALE_SH=6 so clipping is reachable.
// Expected codes are hand-computed and queued at issue time; monitors pop them
// whenever a DUT presents out_valid.
module tb_am_mod_core;

    typedef struct packed {
        logic [13:0] data;
        logic        sat;
    } expT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValidA;
    logic        inValidB;
    logic [9:0]  adcData;
    logic [13:0] carrier;
    logic        askBit;
    logic        cfgMode;
    logic [8:0]  cfgDepth;
    logic [8:0]  cfgSpace;
    logic        cfgLoad;

    logic        cfgBusyA, outValidA, satFlagA;
    logic [13:0] outDataA;
    logic        cfgBusyB, outValidB, satFlagB;
    logic [13:0] outDataB;
`ifdef AM_MOD_CLIP_CNT_EN
    logic [15:0] clipCntA, clipCntB;
`endif

    expT qA[$];
    expT qB[$];
    int  nChecks = 0;
    int  nPass   = 0;

    always #5 clk = ~clk;

    am_mod_core dutA (
        .clk(clk), .rst_n(rst_n), .in_valid(inValidA), .adc_data(adcData),
        .carrier(carrier), .ask_bit(askBit), .cfg_mode(cfgMode),
        .cfg_depth(cfgDepth), .cfg_space(cfgSpace), .cfg_load(cfgLoad),
        .cfg_busy(cfgBusyA), .out_valid(outValidA), .out_data(outDataA),
        .sat_flag(satFlagA)
`ifdef AM_MOD_CLIP_CNT_EN
        , .clip_cnt(clipCntA)
`endif
    );

    am_mod_core #(.SCALE_SH(6)) dutB (
        .clk(clk), .rst_n(rst_n), .in_valid(inValidB), .adc_data(adcData),
        .carrier(carrier), .ask_bit(askBit), .cfg_mode(cfgMode),
        .cfg_depth(cfgDepth), .cfg_space(cfgSpace), .cfg_load(cfgLoad),
        .cfg_busy(cfgBusyB), .out_valid(outValidB), .out_data(outDataB),
        .sat_flag(satFlagB)
`ifdef AM_MOD_CLIP_CNT_EN
        , .clip_cnt(clipCntB)
`endif
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic checkOutput(input string name, input bit haveExp, input expT exp,
                               input logic [13:0] data, input logic sat);
        if (!haveExp) begin
            nChecks++;
            $display("[TB] FAIL %s_unexpected: got out_data %0d, expected no output", name, data);
        end else begin
            checkVal({name, "_data"}, 32'(data), 32'(exp.data));
            checkVal({name, "_sat"}, 32'(sat), 32'(exp.sat));
        end
    endtask

    // Monitors sample on the falling edge, half a cycle away from updates.
    always @(negedge clk) begin
        if (outValidA === 1'b1) begin
            if (qA.size() == 0) checkOutput("dutA", 1'b0, '0, outDataA, satFlagA);
            else checkOutput("dutA", 1'b1, qA.pop_front(), outDataA, satFlagA);
        end
        if (outValidB === 1'b1) begin
            if (qB.size() == 0) checkOutput("dutB", 1'b0, '0, outDataB, satFlagB);
            else checkOutput("dutB", 1'b1, qB.pop_front(), outDataB, satFlagB);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for a cycle and queue what each DUT should emit.
    task automatic applyStimulus(input logic va, input logic vb, input logic [9:0] adc,
                                 input int car, input logic ask,
                                 input logic [13:0] eA, input logic sA,
                                 input logic [13:0] eB, input logic sB);
        inValidA = va;
        inValidB = vb;
        adcData  = adc;
        carrier  = 14'(car);
        askBit   = ask;
        if (va) qA.push_back('{data: eA, sat: sA});
        if (vb) qB.push_back('{data: eB, sat: sB});
        step();
        inValidA = 1'b0;
        inValidB = 1'b0;
    endtask

    // Pulse cfg_load and measure how long cfg_busy stays high. With noisy set,
    // junk samples and a second load are offered while draining.
    task automatic loadCfg(input logic mode, input logic [8:0] depth, input logic [8:0] space,
                           input bit noisy);
        int n;
        cfgMode  = mode;
        cfgDepth = depth;
        cfgSpace = space;
        cfgLoad  = 1'b1;
        step();
        cfgLoad  = 1'b0;
        inValidA = 1'b0;
        n = 0;
        while (cfgBusyA === 1'b1 && n < 20) begin
            if (noisy) begin
                inValidA = 1'b1;
                adcData  = 10'd0;
                carrier  = 14'd1000;
                cfgLoad  = (n == 1);
                cfgDepth = (n == 1) ? 9'd0 : depth;
            end
            step();
            n++;
        end
        inValidA = 1'b0;
        cfgLoad  = 1'b0;
        checkVal("busy_cycles", 32'(n), 32'd4);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((qA.size() != 0 || qB.size() != 0) && n < 50) begin
            step();
            n++;
        end
        checkVal("drain_qA", 32'(qA.size()), 32'd0);
        checkVal("drain_qB", 32'(qB.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; inValidA = 1'b0; inValidB = 1'b0; adcData = '0; carrier = '0;
        askBit = 1'b0; cfgMode = 1'b0; cfgDepth = '0; cfgSpace = '0; cfgLoad = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Reset defaults
        checkVal("rst_out_data", 32'(outDataA), 32'd8192);
        checkVal("rst_out_valid", 32'(outValidA), 32'd0);
        checkVal("rst_cfg_busy", 32'(cfgBusyA), 32'd0);

        // AM, depth 180
        loadCfg(1'b0, 9'd180, 9'd0, 1'b0);
        applyStimulus(1, 0, 10'd512, 8191, 0, 14'd8912, 0, 0, 0);
        applyStimulus(1, 0, 10'd1023, -8192, 0, 14'd6452, 0, 0, 0);
        applyStimulus(1, 0, 10'd0, 1000, 0, 14'd8155, 0, 0, 0);
        waitDrain();

        // ASK, mark 200 / space 0
        loadCfg(1'b1, 9'd200, 9'd0, 1'b0);
        applyStimulus(1, 0, 10'd512, 4096, 1, 14'd8592, 0, 0, 0);
        applyStimulus(1, 0, 10'd512, 4096, 0, 14'd8192, 0, 0, 0);

        // Reconfigure mid-stream: this sample rides with the old ASK config
        inValidA = 1'b1; adcData = 10'd700; carrier = 14'd4096; askBit = 1'b1;
        qA.push_back('{data: 14'd8592, sat: 1'b0});
        loadCfg(1'b0, 9'd180, 9'd0, 1'b1);
        applyStimulus(1, 0, 10'd512, 8191, 0, 14'd8912, 0, 0, 0);
        waitDrain();

        // Saturation on the SCALE_SH=6 instance, AM depth 511
        loadCfg(1'b0, 9'd511, 9'd0, 1'b0);
        applyStimulus(1, 1, 10'd1023, 8191, 0, 14'd11256, 0, 14'd16383, 1);
        applyStimulus(1, 1, 10'd1023, -8192, 0, 14'd5128, 0, 14'd0, 1);
        waitDrain();
        repeat (2) step();
        checkVal("hold_valid", 32'(outValidA), 32'd0);
        checkVal("hold_data", 32'(outDataA), 32'd5128);
        checkVal("hold_sat_b", 32'(satFlagB), 32'd1);
`ifdef AM_MOD_CLIP_CNT_EN
        checkVal("clip_cnt_b", 32'(clipCntB), 32'd2);
        checkVal("clip_cnt_a", 32'(clipCntA), 32'd0);
        loadCfg(1'b0, 9'd511, 9'd0, 1'b0);
        checkVal("clip_cnt_clear", 32'(clipCntB), 32'd0);
`endif

        // Reset in the middle of a stream discards everything in flight
        inValidA = 1'b1; adcData = 10'd1023; carrier = 14'd8191;
        step();
        step();
        inValidA = 1'b0;
        rst_n = 1'b0;
        step();
        checkVal("midrst_valid", 32'(outValidA), 32'd0);
        checkVal("midrst_data", 32'(outDataA), 32'd8192);
        checkVal("midrst_busy", 32'(cfgBusyA), 32'd0);
        rst_n = 1'b1;
        repeat (6) step();

        // Config back to AM depth 0 after reset
        applyStimulus(1, 0, 10'd1023, 8191, 0, 14'd9212, 0, 0, 0);
        waitDrain();
        repeat (3) step();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/am_mod_core.md
Name: am_mod_core

Overview:
- Parametrised, pipelined amplitude modulator for the ADC→DAC chain between the ADC capture block and the DAC.
- Combines an offset-binary ADC sample, or an ASK keying bit, with a signed carrier sample: envelope = signal + depth, then product with the carrier.
- Output is rounded and saturated, then converted to offset-binary DAC code.
- Adds over the previous modulator: runtime depth, runtime mode (AM/ASK), valid handshake, rounding, saturation, and glitch-free reconfiguration via a drain FSM.

Parameters:
- ADC_W, 10, ADC sample width (offset binary).
- CAR_W, 14, carrier width (signed two's complement).
- DEPTH_W, 9, depth/level width (unsigned); must be ≤ ADC_W.
- OUT_W, 14, DAC code width.
- SIG_SH, 1, arithmetic right shift applied to the signed ADC sample.
- SCALE_SH, 11, right shift of the product before output; default = ADC_W+1+CAR_W-OUT_W.
- LAT, 4, pipeline latency in cycles; fixed at 4, exposed for benches.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  sample/carrier strobe.
- adc_data  in  ADC_W  offset-binary ADC sample.
- carrier  in  CAR_W  signed carrier sample.
- ask_bit  in  1  keying bit, used in ASK mode.
- cfg_mode  in  1  0=AM, 1=ASK.
- cfg_depth  in  DEPTH_W  AM carrier offset / ASK mark level.
- cfg_space  in  DEPTH_W  ASK space level.
- cfg_load  in  1  one-cycle pulse: apply cfg_*.
- cfg_busy  out  1  high while a config change drains.
- out_valid  out  1  out_data valid.
- out_data  out  OUT_W  offset-binary DAC code.
- sat_flag  out  1  current output was saturated.

Behaviour:
- Reset: all pipeline valids 0, out_valid 0, out_data = 2^(OUT_W-1) (14'h2000, midscale), sat_flag 0, cfg_busy 0.
  - Active config after reset: mode=AM, depth=0, space=0; FSM in RUN.
  - Reset asserted mid-operation discards all in-flight samples on that edge.
- Stage 1 (registered on in_valid):
  - s = (adc_data − 2^(ADC_W-1)) as signed ADC_W, then arithmetic shift right by SIG_SH.
  - Carrier and ask_bit are registered alongside.
- Stage 2, envelope e (signed, ADC_W+1 bits):
  - AM: e = s + depth.
  - ASK: e = ask_bit ? depth : space.
- Stage 3: p = e × carrier, signed, ADC_W+1+CAR_W bits, full precision.
- Stage 4:
  - y = (p + 2^(SCALE_SH-1)) >>> SCALE_SH (round half up).
  - Saturate y to [−2^(OUT_W-1), 2^(OUT_W-1)−1]; sat_flag=1 when clipped.
  - out_data = {~y[MSB], y[OUT_W-2:0]}. No −1 correction for negative values.
- Latency: exactly LAT=4 cycles from in_valid to out_valid. Full throughput, one sample per cycle, no backpressure.
- out_data and sat_flag hold their last value while out_valid=0.
- FSM states: RUN, DRAIN.
  - RUN + cfg_load: capture cfg_* into shadow registers → DRAIN; cfg_busy=1.
  - DRAIN: inputs ignored (in_valid masked); a counter runs LAT cycles while the pipe empties; out_valid goes 0 once flushed; then shadow→active, → RUN, cfg_busy=0.
  - First post-change sample may enter on the cycle after cfg_busy falls.
  - cfg_load during DRAIN is ignored; it is not queued.
  - cfg_load and in_valid in the same RUN cycle: that sample is accepted with the old config, then DRAIN starts.
- Active config never changes while samples of the old config are in flight. No output mixes two configs.

Optional Feature:
- Macro: AM_MOD_CLIP_CNT_EN.
- Defined:
  - Adds output port clip_cnt [15:0], a saturating count of out_valid cycles with sat_flag=1.
  - Cleared by reset and on every cfg_load accepted in RUN.
  - Holds at 16'hFFFF.
- Undefined: no port, no counter logic. All other behaviour is identical.

Decomposition:
- Package am_mod_pkg:
  - MODE_AM/MODE_ASK constants.
  - FSM state enum (RUN, DRAIN).
  - Midscale-code function.
  - Saturate function parameterised by width.
- One natural sub-module: am_mod_sat_round. It implements the round + saturate + offset-binary stage (stage 4) and is reusable by other DAC paths.

Test Plan:
- Reset, defaults: no in_valid after reset → out_data=8192, out_valid=0, cfg_busy=0.
- AM midscale: load depth=180, mode=AM; after busy falls, adc=512, carrier=8191 → after 4 cycles out_data=8912 (y=720), sat_flag=0.
- AM negative: depth=180, adc=1023 (s=255 after SIG_SH=1), carrier=−8192 → p=−3563520, y=−1740, out_data=6452.
- ASK: mode=ASK, depth=200, space=0, carrier=4096; ask_bit 1 then 0 → out_data 8592 then 8192.
- Saturation (SCALE_SH=6 build): depth=511, adc=1023, carrier=8191 → out_data=16383, sat_flag=1; clip_cnt increments if AM_MOD_CLIP_CNT_EN.
- Reconfig and reset: stream at 1/cycle, pulse cfg_load → cfg_busy high 4 cycles, inputs ignored, no output mixes configs; rst_n low mid-stream → next cycle out_valid=0, out_data=8192.
